// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipeline stage register.
// Occupancy encoding for the skid-mode stage.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } occ_t;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_TAG_W  = 5;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; sticks at all-ones until reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // count up on inc, holding at the maximum value
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_r <= {W{1'b0}};
    end else if (inc && (count_r != {W{1'b1}})) begin
      count_r <= count_r + W'(1);
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pipe_skid_register.sv
// Valid/ready pipeline stage register with optional two-entry skid slot,
// synchronous flush and a saturating downstream-stall counter.
module pipe_skid_register
  import pipe_pkg::*;
#(
  parameter int DATA_W  = PIPE_DATA_W,
  parameter int TAG_W   = PIPE_TAG_W,
  parameter int SKID_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              inValid,
  output logic              inReady,
  input  logic [DATA_W-1:0] inData,
  input  logic [TAG_W-1:0]  inTag,
  output logic              outValid,
  input  logic              outReady,
  output logic [DATA_W-1:0] outData,
  output logic [TAG_W-1:0]  outTag,
  output logic [CNT_W-1:0]  stallCount
);

  logic out_valid_s;
  logic stall_inc_s;

  generate
    if (SKID_EN != 0) begin : g_skid
      occ_t              state_r;
      occ_t              state_nxt_s;
      logic [DATA_W-1:0] main_data_r;
      logic [TAG_W-1:0]  main_tag_r;
      logic [DATA_W-1:0] skid_data_r;
      logic [TAG_W-1:0]  skid_tag_r;
      logic              push_s;
      logic              pop_s;
      logic              main_from_in_s;
      logic              main_from_skid_s;
      logic              skid_load_s;

      assign push_s = inValid && (state_r != FULL);
      assign pop_s  = (state_r != EMPTY) && outReady;

      // next occupancy and slot load enables; flush overrides any handshake
      always_comb begin
        state_nxt_s      = state_r;
        main_from_in_s   = 1'b0;
        main_from_skid_s = 1'b0;
        skid_load_s      = 1'b0;
        if (flush) begin
          state_nxt_s = EMPTY;
        end else begin
          case (state_r)
            EMPTY: begin
              if (push_s) begin
                state_nxt_s    = HALF;
                main_from_in_s = 1'b1;
              end else begin
                state_nxt_s = EMPTY;
              end
            end
            HALF: begin
              if (push_s && pop_s) begin
                state_nxt_s    = HALF;
                main_from_in_s = 1'b1;
              end else if (push_s) begin
                state_nxt_s = FULL;
                skid_load_s = 1'b1;
              end else if (pop_s) begin
                state_nxt_s = EMPTY;
              end else begin
                state_nxt_s = HALF;
              end
            end
            FULL: begin
              if (pop_s) begin
                state_nxt_s      = HALF;
                main_from_skid_s = 1'b1;
              end else begin
                state_nxt_s = FULL;
              end
            end
            default: begin
              state_nxt_s = EMPTY;
            end
          endcase
        end
      end

      // occupancy register
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          state_r <= EMPTY;
        end else begin
          state_r <= state_nxt_s;
        end
      end

      // main slot: head entry driving the outputs
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          main_data_r <= {DATA_W{1'b0}};
          main_tag_r  <= {TAG_W{1'b0}};
        end else if (main_from_in_s) begin
          main_data_r <= inData;
          main_tag_r  <= inTag;
        end else if (main_from_skid_s) begin
          main_data_r <= skid_data_r;
          main_tag_r  <= skid_tag_r;
        end
      end

      // skid slot: catches the entry accepted while the head is stalled
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          skid_data_r <= {DATA_W{1'b0}};
          skid_tag_r  <= {TAG_W{1'b0}};
        end else if (skid_load_s) begin
          skid_data_r <= inData;
          skid_tag_r  <= inTag;
        end
      end

      // ready comes from the state register only, never from outReady
      assign inReady     = (state_r != FULL);
      assign out_valid_s = (state_r != EMPTY);
      assign outData     = main_data_r;
      assign outTag      = main_tag_r;
    end else begin : g_single
      logic              valid_r;
      logic [DATA_W-1:0] data_r;
      logic [TAG_W-1:0]  tag_r;
      logic              in_ready_s;
      logic              push_s;
      logic              pop_s;

      assign in_ready_s = !valid_r || outReady;
      assign push_s     = inValid && in_ready_s;
      assign pop_s      = valid_r && outReady;

      // slot valid; flush wins over push and pop
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          valid_r <= 1'b0;
        end else if (flush) begin
          valid_r <= 1'b0;
        end else if (push_s) begin
          valid_r <= 1'b1;
        end else if (pop_s) begin
          valid_r <= 1'b0;
        end
      end

      // payload register
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          data_r <= {DATA_W{1'b0}};
          tag_r  <= {TAG_W{1'b0}};
        end else if (push_s && !flush) begin
          data_r <= inData;
          tag_r  <= inTag;
        end
      end

      assign inReady     = in_ready_s;
      assign out_valid_s = valid_r;
      assign outData     = data_r;
      assign outTag      = tag_r;
    end
  endgenerate

  assign outValid    = out_valid_s;
  assign stall_inc_s = out_valid_s && !outReady;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (stall_inc_s),
    .count (stallCount)
  );

endmodule

// File: tb/tb_pipe_skid_register.sv
// Bench: skid-mode (CNT_W=2) and single-register instances against a queue model.
module tb_pipe_skid_register;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        inValid = 1'b0;
  logic        outReady = 1'b0;
  logic [31:0] inData = 32'h0;
  logic [4:0]  inTag = 5'h0;

  logic        s_inReady, s_outValid;
  logic [31:0] s_outData;
  logic [4:0]  s_outTag;
  logic [1:0]  s_stall;
  logic        r_inReady, r_outValid;
  logic [31:0] r_outData;
  logic [4:0]  r_outTag;
  logic [15:0] r_stall;

  pipe_skid_register #(.DATA_W(32), .TAG_W(5), .SKID_EN(1), .CNT_W(2)) u_skid (
    .clock(clock), .reset(reset), .flush(flush),
    .inValid(inValid), .inReady(s_inReady), .inData(inData), .inTag(inTag),
    .outValid(s_outValid), .outReady(outReady), .outData(s_outData), .outTag(s_outTag),
    .stallCount(s_stall)
  );

  pipe_skid_register #(.DATA_W(32), .TAG_W(5), .SKID_EN(0), .CNT_W(16)) u_reg (
    .clock(clock), .reset(reset), .flush(flush),
    .inValid(inValid), .inReady(r_inReady), .inData(inData), .inTag(inTag),
    .outValid(r_outValid), .outReady(outReady), .outData(r_outData), .outTag(r_outTag),
    .stallCount(r_stall)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  t;
  } ent_t;

  ent_t qs[$];
  ent_t qr[$];
  int   cs = 0;
  int   cr = 0;
  int   errors = 0;
  int   checks = 0;
  bit   cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    qs.delete();
    qr.delete();
    cs = 0;
    cr = 0;
  endtask

  // One clock edge of the queue model, using the inputs held across the edge.
  task automatic model_step();
    int  ss;
    int  sr;
    bit  s_pop, s_push, r_pop, r_push;
    if (!reset) begin
      model_clear();
    end else begin
      ss = qs.size();
      sr = qr.size();
      s_pop  = (ss > 0) && outReady;
      s_push = inValid && (ss < 2);
      r_pop  = (sr > 0) && outReady;
      r_push = inValid && ((sr == 0) || outReady);
      if ((ss > 0) && !outReady && (cs < 3)) cs++;
      if ((sr > 0) && !outReady && (cr < 65535)) cr++;
      if (flush) begin
        qs.delete();
        qr.delete();
      end else begin
        if (s_pop) void'(qs.pop_front());
        if (s_push) qs.push_back('{d: inData, t: inTag});
        if (r_pop) void'(qr.pop_front());
        if (r_push) qr.push_back('{d: inData, t: inTag});
      end
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] d, input logic [4:0] t,
                       input bit ordy, input bit fl);
    @(posedge clock);
    model_step();
    #2;
    inValid  = v;
    inData   = d;
    inTag    = t;
    outReady = ordy;
    flush    = fl;
  endtask

  task automatic assert_reset();
    @(posedge clock);
    model_step();
    #2;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic release_reset();
    @(posedge clock);
    model_step();
    #2;
    reset = 1'b1;
  endtask

  task automatic wait_neg();
    @(negedge clock);
    #1;
  endtask

  // Cycle-by-cycle comparison of both instances against the model.
  always @(negedge clock) begin
    if (cmp_en) begin
      check("s_outValid", s_outValid, qs.size() > 0);
      check("s_inReady", s_inReady, qs.size() < 2);
      if (qs.size() > 0) begin
        check("s_outData", s_outData, qs[0].d);
        check("s_outTag", s_outTag, qs[0].t);
      end
      check("s_stall", s_stall, cs);
      check("r_outValid", r_outValid, qr.size() > 0);
      check("r_inReady", r_inReady, (qr.size() == 0) || outReady);
      if (qr.size() > 0) begin
        check("r_outData", r_outData, qr[0].d);
        check("r_outTag", r_outTag, qr[0].t);
      end
      check("r_stall", r_stall, cr);
    end
  end

  int stall_exp [5] = '{1, 2, 3, 3, 3};

  initial begin
    reset    = 1'b0;
    inValid  = 1'b1;
    inData   = 32'hDEADBEEF;
    inTag    = 5'd7;
    outReady = 1'b1;
    drive(1'b1, 32'hDEADBEEF, 5'd7, 1'b1, 1'b0);
    cmp_en = 1'b1;
    drive(1'b1, 32'hDEADBEEF, 5'd7, 1'b1, 1'b0);
    wait_neg();
    check("rst_s_outValid", s_outValid, 1'b0);
    check("rst_s_outData", s_outData, 32'h0);
    check("rst_s_stall", s_stall, 2'd0);
    check("rst_s_inReady", s_inReady, 1'b1);
    check("rst_r_inReady", r_inReady, 1'b1);
    check("rst_r_outValid", r_outValid, 1'b0);
    release_reset();
    drive(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
    wait_neg();
    check("first_s_data", s_outData, 32'hDEADBEEF);
    check("first_s_tag", s_outTag, 5'd7);
    check("first_r_data", r_outData, 32'hDEADBEEF);

    // streaming at full rate
    drive(1'b1, 32'h1, 5'd1, 1'b1, 1'b0);
    drive(1'b1, 32'h2, 5'd2, 1'b1, 1'b0);
    wait_neg();
    check("stream_1", s_outData, 32'h1);
    drive(1'b1, 32'h3, 5'd3, 1'b1, 1'b0);
    wait_neg();
    check("stream_2", s_outData, 32'h2);
    check("stream_ready", s_inReady, 1'b1);
    drive(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
    wait_neg();
    check("stream_3", s_outData, 32'h3);
    drive(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);

    // backpressure into FULL, then drain in order
    drive(1'b1, 32'hA, 5'd1, 1'b0, 1'b0);
    drive(1'b1, 32'hB, 5'd2, 1'b0, 1'b0);
    drive(1'b1, 32'hC, 5'd3, 1'b0, 1'b0);
    wait_neg();
    check("full_ready", s_inReady, 1'b0);
    check("full_head", s_outData, 32'hA);
    drive(1'b1, 32'hC, 5'd3, 1'b1, 1'b0);
    wait_neg();
    check("full_ready2", s_inReady, 1'b0);
    check("pop_A", s_outData, 32'hA);
    check("single_comb_ready", r_inReady, 1'b1);
    drive(1'b1, 32'hC, 5'd3, 1'b1, 1'b0);
    wait_neg();
    check("pop_B", s_outData, 32'hB);
    check("single_C", r_outData, 32'hC);
    drive(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
    wait_neg();
    check("pop_C", s_outData, 32'hC);
    drive(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
    wait_neg();
    check("drained", s_outValid, 1'b0);

    // flush while FULL with a push offered
    drive(1'b1, 32'hA, 5'd1, 1'b0, 1'b0);
    drive(1'b1, 32'hB, 5'd2, 1'b0, 1'b0);
    drive(1'b1, 32'hC, 5'd3, 1'b0, 1'b1);
    wait_neg();
    check("preflush_ready", s_inReady, 1'b0);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    wait_neg();
    check("flush_s_valid", s_outValid, 1'b0);
    check("flush_s_ready", s_inReady, 1'b1);
    check("flush_r_valid", r_outValid, 1'b0);
    repeat (3) drive(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);

    // fresh counter: stall saturation with CNT_W=2
    assert_reset();
    drive(1'b1, 32'h5, 5'd5, 1'b0, 1'b0);
    release_reset();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    wait_neg();
    check("stall_0", s_stall, 2'd0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
      wait_neg();
      check("stall_seq", s_stall, stall_exp[i]);
    end

    // single-register mode: combinational ready through outReady
    drive(1'b1, 32'h6, 5'd6, 1'b0, 1'b0);
    wait_neg();
    check("single_blocked", r_inReady, 1'b0);
    drive(1'b1, 32'h6, 5'd6, 1'b1, 1'b0);
    wait_neg();
    check("single_open", r_inReady, 1'b1);
    drive(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
    wait_neg();
    check("single_next", r_outData, 32'h6);

    // randomized traffic with occasional flush and mid-run reset
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        assert_reset();
        release_reset();
      end else begin
        drive($urandom_range(0, 3) != 0, $urandom, 5'($urandom_range(0, 31)),
              $urandom_range(0, (n / 500) % 3 + 1) != 0, $urandom_range(0, 31) == 0);
      end
    end
    drive(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
    wait_neg();
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_skid_register.md
# pipe_skid_register

Parametrised pipeline stage register with a valid/ready handshake, replacing hard-wired stall-only stage registers between processor stages. An optional two-entry skid slot fully registers the backpressure path, so `inReady` depends on no downstream combinational signal. A synchronous flush squashes in-flight entries, and a saturating counter records downstream-stall cycles for performance analysis. It sits between any two pipeline stages, e.g. execute → memory/writeback.

## Interface
- `DATA_W`, 32: payload width in bits; the payload is any packed bundle such as ALU result, store data, PC.
- `TAG_W`, 5: sideband tag width, e.g. destination register address.
- `SKID_EN`, 1: 1 selects the two-entry skid mode; 0 selects the single-register mode.
- `CNT_W`, 16: stall counter width.

Ports:
- `clock`, input, 1: the only clock; rising edge.
- `reset`, input, 1: asynchronous, active-low reset. Asserts immediately, releases synchronously with `clock`.
- `flush`, input, 1: synchronous squash of all held entries.
- `inValid`, input, 1: upstream offers an entry.
- `inReady`, output, 1: stage can accept an entry.
- `inData`, input, `DATA_W`: upstream payload.
- `inTag`, input, `TAG_W`: upstream tag.
- `outValid`, output, 1: stage presents an entry.
- `outReady`, input, 1: downstream accepts the entry.
- `outData`, output, `DATA_W`: payload of the head entry.
- `outTag`, output, `TAG_W`: tag of the head entry.
- `stallCount`, output, `CNT_W`: count of stall cycles.

## Operation
- Handshake definitions:
  - Accept (push) = `inValid && inReady`.
  - Issue (pop) = `outValid && outReady`.
  - Once `outValid` is high, `outData` and `outTag` stay stable until the pop or a flush.
- Storage: a main slot holds the head entry and drives `out*`; a skid slot exists only when `SKID_EN`=1.
- Occupancy states in skid mode:
  - EMPTY: main and skid both empty.
  - HALF: main holds an entry, skid is empty.
  - FULL: main and skid both hold entries.
- Transitions in skid mode:
  - EMPTY, on push → HALF; main takes the input.
  - HALF, push and pop → HALF; main takes the input.
  - HALF, push and no pop → FULL; skid takes the input.
  - HALF, pop and no push → EMPTY.
  - FULL, on pop → HALF; main takes skid.
  - FULL: no push is possible, because `inReady`=0.
- `inReady` in skid mode is `state != FULL`, decoded from registers only.
- Single-register mode (`SKID_EN`=0):
  - `inReady` = `!outValid || outReady` (combinational).
  - Main takes the input on push.
  - Push and pop in the same cycle keeps the slot full with the new entry.
- Flush:
  - Has priority over push and pop.
  - Next state is EMPTY; any push in the flush cycle is discarded.
  - Data registers hold their values; only the valids clear.
- `stallCount` increments each cycle in which `outValid && !outReady`.
  - It saturates at 2^`CNT_W`−1.
  - It counts during flush cycles if the condition holds.
  - Only reset clears it.

## Timing
- Reset values: `outValid`=0, `outData`=0, `outTag`=0, `stallCount`=0, state EMPTY.
  - `inReady`=1 in skid mode.
  - `inReady`=`1` in single-register mode, since `outValid`=0.
- Latency: a pushed entry appears on `out*` the next cycle when the stage was EMPTY or popping. Minimum latency is 1 cycle.
- Throughput: 1 entry per cycle in both modes under continuous `outReady`=1.
- `inReady` falls to 0 the cycle after FULL is entered and rises the cycle after the pop that leaves FULL.
- Reset asserted mid-operation drops all entries at once, with no handshake completed.

## Structure
- Package `pipe_pkg` contains:
  - `typedef enum logic [1:0] {EMPTY, HALF, FULL} occ_t`.
  - The default width constants `PIPE_DATA_W`=32 and `PIPE_TAG_W`=5.
- Sub-module `sat_counter` (parameter `W`; ports `clock`, `reset`, `inc`, `count`) implements the stall counter.
- The skid slot is a `generate` branch on `SKID_EN`.

## Test plan
- Reset with `inValid`=1 held → `outValid`=0, `outData`=0, `stallCount`=0, `inReady`=1. After release, push 0xDEADBEEF/tag 7 → next cycle `outData`=0xDEADBEEF, `outTag`=7.
- Skid mode, `outReady`=1, stream 0x1,0x2,0x3 on consecutive cycles → outputs 0x1,0x2,0x3 on consecutive cycles; `inReady` never drops.
- Skid mode, `outReady`=0, push 0xA then 0xB → `inReady`=0 from the following cycle and 0xC is not taken. Raise `outReady` → pops in order 0xA, 0xB, 0xC with no loss or duplication.
- FULL with 0xA/0xB held, assert `flush` together with push 0xC → next cycle `outValid`=0, `inReady`=1, and 0xC never appears.
- `CNT_W`=2, hold `outValid`=1 and `outReady`=0 for 5 cycles → `stallCount` reads 1,2,3,3,3.
- `SKID_EN`=0, `outReady`=0 with entry 0x5 held and push 0x6 offered → `inReady`=0. Raise `outReady` in the same cycle → `inReady`=1 combinationally, and the next cycle `outData`=0x6.
